// File: rtl/control_types.sv
// Shared control types: memory access kinds, arbiter states, arbiter defaults.
package control_types;

  // Width/sign of a memory access; the memory performs extension on loads.
  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_HALF   = 3'd1,
    MEM_WORD   = 3'd2,
    MEM_BYTE_U = 3'd4,
    MEM_HALF_U = 3'd5
  } mem_op_t;

  // Unified-memory port arbiter states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_IF = 3'd1,
    ISSUE_D  = 3'd2,
    RESP_IF  = 3'd3,
    RESP_D   = 3'd4
  } arb_state_t;

  // Default number of back-to-back data grants a waiting fetch tolerates.
  localparam int FETCH_STARVE_DEF = 4;

  // Access command captured at grant time and replayed onto the memory port.
  typedef struct packed {
    logic        wr;
    mem_op_t     op;
    logic [31:0] wdata;
  } acc_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating starvation counter: counts data grants that bypassed a waiting fetch.
module mem_arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic sat
);
  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  // Clear has priority; increment stops once saturated.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (inc && !sat)  cnt <= cnt + CW'(1);
  end

  assign sat = (cnt == CW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported, registered-read memory.
module mem_port_arbiter
  import control_types::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FETCH_STARVE = FETCH_STARVE_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  // data port
  input  logic              d_req,
  input  logic              d_wr_en,
  input  mem_op_t           d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  // memory port
  output logic              m_wr_en,
  output mem_op_t           m_op,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  arb_state_t        state, state_nxt;
  logic              grant_if, grant_d;
  logic              starve_sat;
  acc_cmd_t          cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       if_hold_q, d_hold_q;
  logic              unused_if_lo;

  // Fetches are always word accesses; the low address bits are dropped.
  assign unused_if_lo = ^if_addr[1:0];

  mem_arb_starve_ctr #(.MAX(FETCH_STARVE)) u_starve (
    .clk    (clk),
    .resetn (resetn),
    .clr    (grant_if | ~if_req),
    .inc    (grant_d),
    .sat    (starve_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and grant decision; response states re-arbitrate like IDLE.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE, RESP_IF, RESP_D: begin
        if (if_req && (!d_req || starve_sat)) begin
          grant_if  = 1'b1;
          state_nxt = ISSUE_IF;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = ISSUE_D;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE_IF: state_nxt = RESP_IF;
      ISSUE_D:  state_nxt = RESP_D;
      default:  state_nxt = IDLE;
    endcase
  end

  // Capture the winner's command at grant; it stays on the memory port until the next grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q  <= '{wr: 1'b0, op: MEM_WORD, wdata: '0};
      addr_q <= '0;
    end else if (grant_if) begin
      cmd_q  <= '{wr: 1'b0, op: MEM_WORD, wdata: '0};
      addr_q <= {if_addr[ADDR_W-1:2], 2'b00};
    end else if (grant_d) begin
      cmd_q  <= '{wr: d_wr_en, op: d_op, wdata: d_wdata};
      addr_q <= d_addr;
    end
  end

  assign m_wr_en = (state == ISSUE_D) && cmd_q.wr;
  assign m_op    = cmd_q.op;
  assign m_addr  = addr_q;
  assign m_wdata = cmd_q.wdata;

  // A response is only reported while its requester still wants it.
  assign if_valid = (state == RESP_IF) && if_req;
  assign d_valid  = (state == RESP_D)  && d_req;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req  & ~d_valid;

  // Hold the last delivered read data between responses; stores leave d_rdata alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      if (if_valid)              if_hold_q <= m_rdata;
      if (d_valid && !cmd_q.wr)  d_hold_q  <= m_rdata;
    end
  end

  // Read data is forwarded straight from memory in the response cycle.
  assign if_rdata = if_valid ? m_rdata : if_hold_q;
  assign d_rdata  = (d_valid && !cmd_q.wr) ? m_rdata : d_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read memory.
module tb_mem_port_arbiter;
  import control_types::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_wr_en, d_valid, d_stall;
  mem_op_t     d_op, m_op;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_wr_en;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:1023];
  bit         loaded = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .FETCH_STARVE(4)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_wr_en(d_wr_en), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .m_wr_en(m_wr_en), .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  function automatic logic [31:0] rd(input logic [31:0] a, input mem_op_t op);
    logic [9:0] i;
    i = a[9:0];
    case (op)
      MEM_BYTE:   rd = {{24{mem[i][7]}}, mem[i]};
      MEM_BYTE_U: rd = {24'h0, mem[i]};
      MEM_HALF:   rd = {{16{mem[i+1][7]}}, mem[i+1], mem[i]};
      MEM_HALF_U: rd = {16'h0, mem[i+1], mem[i]};
      default:    rd = {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endcase
  endfunction

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a]   = w[7:0];
    mem[a+1] = w[15:8];
    mem[a+2] = w[23:16];
    mem[a+3] = w[31:24];
  endtask

  // Memory: preload once, then registered read (old data) and byte-lane writes.
  always @(posedge clk) begin
    logic [9:0] i;
    if (!loaded) begin
      for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
      put_word(0,     32'h00500093);
      put_word(4,     32'h00a00113);
      put_word(8,     32'h002081b3);
      put_word(12'h100, 32'h11223344);
      put_word(12'h104, 32'h55667788);
      loaded = 1'b1;
    end
    m_rdata <= rd(m_addr, m_op);
    i = m_addr[9:0];
    if (m_wr_en) begin
      case (m_op)
        MEM_BYTE, MEM_BYTE_U: mem[i] = m_wdata[7:0];
        MEM_HALF, MEM_HALF_U: begin mem[i] = m_wdata[7:0]; mem[i+1] = m_wdata[15:8]; end
        default: begin
          mem[i] = m_wdata[7:0]; mem[i+1] = m_wdata[15:8];
          mem[i+2] = m_wdata[23:16]; mem[i+3] = m_wdata[31:24];
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [31:0] fa [4];
  logic [31:0] fm [4];
  logic [31:0] fd [4];
  byte         exp_ord [10];
  byte         got;
  int          n;

  initial begin
    fa = '{32'h0, 32'h4, 32'h8, 32'h6};
    fm = '{32'h0, 32'h4, 32'h8, 32'h4};
    fd = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00a00113};
    exp_ord = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};

    resetn = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_wr_en = 1'b0; d_op = MEM_WORD; d_addr = '0; d_wdata = '0;

    // Reset values
    tick(); tick();
    chk("rst_m_wr_en", 32'(m_wr_en), 0);
    chk("rst_m_op",    32'(m_op), 32'(MEM_WORD));
    chk("rst_m_addr",  m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_d_valid", 32'(d_valid), 0);
    chk("rst_if_stall", 32'(if_stall), 0);
    if_req = 1'b1; d_req = 1'b1; #1;
    chk("rst_if_stall_req", 32'(if_stall), 1);
    chk("rst_d_stall_req",  32'(d_stall), 1);
    if_req = 1'b0; d_req = 1'b0;
    tick(); resetn = 1'b1; tick();

    // Fetch stream, including a misaligned address
    for (int k = 0; k < 4; k++) begin
      if_req = 1'b1; if_addr = fa[k];
      tick();
      chk($sformatf("fetch%0d_issue_valid", k), 32'(if_valid), 0);
      chk($sformatf("fetch%0d_issue_stall", k), 32'(if_stall), 1);
      chk($sformatf("fetch%0d_m_addr", k), m_addr, fm[k]);
      chk($sformatf("fetch%0d_m_op", k), 32'(m_op), 32'(MEM_WORD));
      tick();
      chk($sformatf("fetch%0d_valid", k), 32'(if_valid), 1);
      chk($sformatf("fetch%0d_rdata", k), if_rdata, fd[k]);
      chk($sformatf("fetch%0d_stall", k), 32'(if_stall), 0);
    end
    if_req = 1'b0;

    // Byte store to 512, then load it back
    d_req = 1'b1; d_wr_en = 1'b1; d_op = MEM_BYTE; d_addr = 32'd512; d_wdata = 32'h69;
    tick();
    chk("st_m_wr_en", 32'(m_wr_en), 1);
    chk("st_m_addr", m_addr, 512);
    chk("st_m_wdata", m_wdata, 32'h69);
    chk("st_d_stall", 32'(d_stall), 1);
    tick();
    chk("st_m_wr_en_off", 32'(m_wr_en), 0);
    chk("st_d_valid", 32'(d_valid), 1);
    chk("st_d_rdata_hold", d_rdata, 0);
    chk("st_mem512", 32'(mem[512]), 32'h69);
    d_wr_en = 1'b0; d_op = MEM_BYTE_U;
    tick();
    chk("ld_m_wr_en", 32'(m_wr_en), 0);
    chk("ld_issue_valid", 32'(d_valid), 0);
    tick();
    chk("ld_d_valid", 32'(d_valid), 1);
    chk("ld_d_rdata", d_rdata, 32'h69);
    d_req = 1'b0;
    tick();

    // Contention with starvation limit 4
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_wr_en = 1'b0; d_op = MEM_WORD; d_addr = 32'h100;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      tick();
      chk($sformatf("cont_c%0d_not_both", c), 32'(if_valid & d_valid), 0);
      if (if_valid || d_valid) begin
        got = if_valid ? "I" : "D";
        chk($sformatf("cont_grant%0d", n), 32'(got), 32'(exp_ord[n]));
        if (if_valid) chk($sformatf("cont_if_rdata%0d", n), if_rdata, 32'h00500093);
        else begin
          chk($sformatf("cont_d_rdata%0d", n), d_rdata, 32'h11223344);
          chk($sformatf("cont_if_stall%0d", n), 32'(if_stall), 1);
        end
        n++;
      end
    end
    chk("cont_grant_count", n, 10);
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Back-to-back loads
    d_req = 1'b1; d_wr_en = 1'b0; d_op = MEM_WORD; d_addr = 32'h100;
    tick();
    chk("b2b_n1_valid", 32'(d_valid), 0);
    tick();
    chk("b2b_n2_valid", 32'(d_valid), 1);
    chk("b2b_n2_rdata", d_rdata, 32'h11223344);
    d_addr = 32'h104;
    tick();
    chk("b2b_n3_valid", 32'(d_valid), 0);
    tick();
    chk("b2b_n4_valid", 32'(d_valid), 1);
    chk("b2b_n4_rdata", d_rdata, 32'h55667788);
    d_req = 1'b0;
    tick();

    // Reset during ISSUE_D of a word store
    d_req = 1'b1; d_wr_en = 1'b1; d_op = MEM_WORD; d_addr = 32'd520; d_wdata = 32'hdeadbeef;
    tick();
    chk("rs_issue_wr_en", 32'(m_wr_en), 1);
    chk("rs_issue_addr", m_addr, 520);
    resetn = 1'b0; #1;
    chk("rs_m_wr_en", 32'(m_wr_en), 0);
    chk("rs_m_addr", m_addr, 0);
    chk("rs_m_wdata", m_wdata, 0);
    chk("rs_m_op", 32'(m_op), 32'(MEM_WORD));
    chk("rs_d_rdata", d_rdata, 0);
    chk("rs_if_rdata", if_rdata, 0);
    chk("rs_d_valid", 32'(d_valid), 0);
    chk("rs_d_stall", 32'(d_stall), 1);
    tick();
    chk("rs_mem520", rd(32'd520, MEM_WORD), 0);
    chk("rs_m_wr_en_held", 32'(m_wr_en), 0);
    d_req = 1'b0; d_wr_en = 1'b0;
    resetn = 1'b1;
    tick();

    // Load abandoned in its response cycle, then a normal fetch
    d_req = 1'b1; d_wr_en = 1'b0; d_op = MEM_WORD; d_addr = 32'h104;
    tick();
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    chk("drop_d_valid", 32'(d_valid), 0);
    chk("drop_d_rdata", d_rdata, 0);
    if_req = 1'b1; if_addr = 32'h8;
    tick();
    chk("drop_if_issue_valid", 32'(if_valid), 0);
    tick();
    chk("drop_if_valid", 32'(if_valid), 1);
    chk("drop_if_rdata", if_rdata, 32'h002081b3);
    if_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
